// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the OTTER pipeline/long-latency units and the register file write arbiter.
// The master drives requests; the slave (the arbiter) returns write-port and status signals.
interface regfile_wb_arbiter_if;
  logic        PIPE_EN;
  logic [4:0]  PIPE_WA;
  logic [31:0] PIPE_WD;
  logic        LL_VALID;
  logic [4:0]  LL_WA;
  logic [31:0] LL_WD;
  logic        LL_READY;
  logic        RSV_EN;
  logic [4:0]  RSV_WA;
  logic [4:0]  Q_ADR1;
  logic [4:0]  Q_ADR2;
  logic        Q_BUSY1;
  logic        Q_BUSY2;
  logic        STALL_REQ;
  logic        RF_EN;
  logic [4:0]  RF_WA;
  logic [31:0] RF_WD;

  modport master (
    output PIPE_EN, PIPE_WA, PIPE_WD, LL_VALID, LL_WA, LL_WD, RSV_EN, RSV_WA, Q_ADR1, Q_ADR2,
    input  LL_READY, Q_BUSY1, Q_BUSY2, STALL_REQ, RF_EN, RF_WA, RF_WD
  );

  modport slave (
    input  PIPE_EN, PIPE_WA, PIPE_WD, LL_VALID, LL_WA, LL_WD, RSV_EN, RSV_WA, Q_ADR1, Q_ADR2,
    output LL_READY, Q_BUSY1, Q_BUSY2, STALL_REQ, RF_EN, RF_WA, RF_WD
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Merges pipeline writeback with buffered long-latency results onto the single RF write port,
// tracking pending destinations for decode and requesting a stall when the buffer starves.
module regfile_wb_arbiter #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input logic               CLK,
  input logic               RST,
  regfile_wb_arbiter_if.slave bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [4:0]    mem_wa_q [DEPTH];
  logic [31:0]   mem_wd_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   pending_q, pending_d;
  logic [7:0]    starve_q, starve_d;

  logic          full, empty, ll_ready, ll_acc, push, pipe_wr, pop;
  logic [4:0]    head_wa;
  logic [31:0]   head_wd;
  logic          hit1, hit2;
  logic [PW-1:0] offs;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign ll_ready = !full && !RST;
  assign ll_acc   = bus.LL_VALID && ll_ready;
  assign push     = ll_acc && (bus.LL_WA != 5'd0);
  assign pipe_wr  = bus.PIPE_EN && (bus.PIPE_WA != 5'd0);
  assign pop      = !empty && !pipe_wr && !RST;
  assign head_wa  = mem_wa_q[rd_ptr_q];
  assign head_wd  = mem_wd_q[rd_ptr_q];

  assign bus.LL_READY = ll_ready;

  always_comb begin
    bus.RF_EN = 1'b0;
    bus.RF_WA = 5'd0;
    bus.RF_WD = 32'd0;
    if (!RST) begin
      if (pipe_wr) begin
        bus.RF_EN = 1'b1;
        bus.RF_WA = bus.PIPE_WA;
        bus.RF_WD = bus.PIPE_WD;
      end else if (!empty) begin
        bus.RF_EN = 1'b1;
        bus.RF_WA = head_wa;
        bus.RF_WD = head_wd;
      end
    end
  end

  // Buffered and in-flight results count as busy until they have actually reached the RF.
  always_comb begin
    hit1 = ll_acc && (bus.LL_WA == bus.Q_ADR1);
    hit2 = ll_acc && (bus.LL_WA == bus.Q_ADR2);
    offs = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs = PW'(i) - rd_ptr_q;
      if ({1'b0, offs} < cnt_q) begin
        if (mem_wa_q[i] == bus.Q_ADR1) hit1 = 1'b1;
        if (mem_wa_q[i] == bus.Q_ADR2) hit2 = 1'b1;
      end
    end
    bus.Q_BUSY1 = !RST && (bus.Q_ADR1 != 5'd0) && (pending_q[bus.Q_ADR1] || hit1);
    bus.Q_BUSY2 = !RST && (bus.Q_ADR2 != 5'd0) && (pending_q[bus.Q_ADR2] || hit2);
  end

  assign bus.STALL_REQ = !RST && !empty && (starve_q == 8'(STARVE_MAX));

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;

    pending_d = pending_q;
    if (pop) pending_d[head_wa] = 1'b0;
    if (bus.RSV_EN && (bus.RSV_WA != 5'd0)) pending_d[bus.RSV_WA] = 1'b1;
    pending_d[0] = 1'b0;

    starve_d = starve_q;
    if (empty || pop) starve_d = 8'd0;
    else if (pipe_wr && (starve_q < 8'(STARVE_MAX))) starve_d = starve_q + 8'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      pending_q <= '0;
      starve_q  <= 8'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      starve_q  <= starve_d;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_wa_q[wr_ptr_q] <= bus.LL_WA;
      mem_wd_q[wr_ptr_q] <= bus.LL_WD;
    end
  end

endmodule
